// File: rtl/axil_reg_bank_pkg.sv
// Shared types, response codes and helpers for the AXI4-Lite register bank.
package axil_reg_bank_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [STRB_W-1:0] strb_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index of a byte address; the two byte-offset bits are dropped.
  function automatic logic [31:0] reg_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic word_t strb_merge(input word_t old_w, input word_t new_w, input strb_t strb);
    word_t r;
    r = old_w;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic even_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/axil_reg_bank_wr_ctrl.sv
// Write-side control: independent AW/W holding buffers, commit strobe and B channel.
module axil_reg_bank_wr_ctrl
  import axil_reg_bank_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  word_t             wdata_i,
  input  strb_t             wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              wen_o,
  output logic [31:0]       widx_o,
  output word_t             wdata_o,
  output strb_t             wstrb_o
);

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  word_t             w_data_q, w_data_d;
  strb_t             w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic        commit;
  logic        idx_ok;
  logic [31:0] idx;

  assign awready_o = !aw_full_q && !bvalid_q;
  assign wready_o  = !w_full_q && !bvalid_q;
  assign commit    = aw_full_q && w_full_q && !bvalid_q;
  assign idx       = reg_index(32'(aw_addr_q));
  assign idx_ok    = idx < NUM_REGS;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (awvalid_i && awready_o) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr_i;
    end
    if (wvalid_i && wready_o) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end
    // Buffers cannot refill while committing: both readies are low when full.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = idx_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign wen_o    = commit && idx_ok;
  assign widx_o   = idx;
  assign wdata_o  = w_data_q;
  assign wstrb_o  = w_strb_q;

endmodule

// File: rtl/axil_reg_bank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes and decode errors.
// Define AXIL_REG_BANK_PARITY_EN to add per-register even parity and sticky error flags.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          S_AWADDR,
  input  logic                       S_AWVALID,
  output logic                       S_AWREADY,
  input  logic [DATA_W-1:0]          S_WDATA,
  input  logic [DATA_W/8-1:0]        S_WSTRB,
  input  logic                       S_WVALID,
  output logic                       S_WREADY,
  output logic [1:0]                 S_BRESP,
  output logic                       S_BVALID,
  input  logic                       S_BREADY,
  input  logic [ADDR_W-1:0]          S_ARADDR,
  input  logic                       S_ARVALID,
  output logic                       S_ARREADY,
  output logic [DATA_W-1:0]          S_RDATA,
  output logic [1:0]                 S_RRESP,
  output logic                       S_RVALID,
  input  logic                       S_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse,
  output logic [NUM_REGS-1:0]        parity_err
);

  logic        wen;
  logic [31:0] widx;
  word_t       wdata_c;
  strb_t       wstrb_c;

  axil_reg_bank_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_ctrl (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .awaddr_i  (S_AWADDR),
    .awvalid_i (S_AWVALID),
    .awready_o (S_AWREADY),
    .wdata_i   (S_WDATA),
    .wstrb_i   (S_WSTRB),
    .wvalid_i  (S_WVALID),
    .wready_o  (S_WREADY),
    .bresp_o   (S_BRESP),
    .bvalid_o  (S_BVALID),
    .bready_i  (S_BREADY),
    .wen_o     (wen),
    .widx_o    (widx),
    .wdata_o   (wdata_c),
    .wstrb_o   (wstrb_c)
  );

  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       ar_idx;
  logic              ar_ok;
  logic              ar_hs;
  logic [DATA_W-1:0] rd_word;
  logic              rd_perr;
  logic [NUM_REGS-1:0] mismatch;

  assign S_ARREADY = !rvalid_q;
  assign ar_hs     = S_ARVALID && !rvalid_q;
  assign ar_idx    = reg_index(32'(S_ARADDR));
  assign ar_ok     = ar_idx < NUM_REGS;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] data_q;
    logic              pulse_q;
    logic              hit_wr;
    word_t             wr_word;

    assign hit_wr  = wen && (widx == gi);
    assign wr_word = strb_merge(data_q, wdata_c, wstrb_c);

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        data_q  <= RESET_VAL;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= hit_wr;
        if (hit_wr) data_q <= wr_word;
      end
    end

    assign reg_q[gi*DATA_W +: DATA_W] = data_q;
    assign reg_wr_pulse[gi]           = pulse_q;

`ifdef AXIL_REG_BANK_PARITY_EN
    logic par_q;
    logic perr_q;
    logic hit_rd;

    assign hit_rd = ar_hs && ar_ok && (ar_idx == gi);

    // A committed write re-arms the flag even if a read flagged it on the same edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        par_q  <= even_parity(RESET_VAL);
        perr_q <= 1'b0;
      end else if (hit_wr) begin
        par_q  <= even_parity(wr_word);
        perr_q <= 1'b0;
      end else if (hit_rd && mismatch[gi]) begin
        perr_q <= 1'b1;
      end
    end

    assign mismatch[gi]   = even_parity(data_q) != par_q;
    assign parity_err[gi] = perr_q;
`else
    assign mismatch[gi]   = 1'b0;
    assign parity_err[gi] = 1'b0;
`endif
  end

  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (ar_idx == i) begin
        rd_word = reg_q[i*DATA_W +: DATA_W];
        rd_perr = mismatch[i];
      end
    end
  end

  // Read data is sampled from the pre-commit register value on a shared edge.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (ar_ok) begin
        rdata_d = rd_word;
        rresp_d = rd_perr ? RESP_SLVERR : RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && S_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign S_RVALID = rvalid_q;
  assign S_RDATA  = rdata_q;
  assign S_RRESP  = rresp_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank with a per-cycle register/pulse model compare.
module tb_axil_reg_bank;

  localparam int NR = 4;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [7:0]    S_AWADDR = '0;
  logic          S_AWVALID = 1'b0;
  logic          S_AWREADY;
  logic [31:0]   S_WDATA = '0;
  logic [3:0]    S_WSTRB = '0;
  logic          S_WVALID = 1'b0;
  logic          S_WREADY;
  logic [1:0]    S_BRESP;
  logic          S_BVALID;
  logic          S_BREADY = 1'b0;
  logic [7:0]    S_ARADDR = '0;
  logic          S_ARVALID = 1'b0;
  logic          S_ARREADY;
  logic [31:0]   S_RDATA;
  logic [1:0]    S_RRESP;
  logic          S_RVALID;
  logic          S_RREADY = 1'b0;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;
  logic [NR-1:0] parity_err;

  axil_reg_bank #(
    .NUM_REGS  (NR),
    .DATA_W    (32),
    .ADDR_W    (8),
    .RESET_VAL (32'h0)
  ) u_dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .S_AWADDR     (S_AWADDR),
    .S_AWVALID    (S_AWVALID),
    .S_AWREADY    (S_AWREADY),
    .S_WDATA      (S_WDATA),
    .S_WSTRB      (S_WSTRB),
    .S_WVALID     (S_WVALID),
    .S_WREADY     (S_WREADY),
    .S_BRESP      (S_BRESP),
    .S_BVALID     (S_BVALID),
    .S_BREADY     (S_BREADY),
    .S_ARADDR     (S_ARADDR),
    .S_ARVALID    (S_ARVALID),
    .S_ARREADY    (S_ARREADY),
    .S_RDATA      (S_RDATA),
    .S_RRESP      (S_RRESP),
    .S_RVALID     (S_RVALID),
    .S_RREADY     (S_RREADY),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse),
    .parity_err   (parity_err)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  bit chk_en = 1'b0;

  // Behavioural model: architectural register contents, pulse due-cycle, sticky flags.
  logic [31:0]   model_reg [NR];
  int            pulse_cyc [NR];
  logic [NR-1:0] exp_perr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      model_reg[i] = 32'h0;
      pulse_cyc[i] = -1;
    end
    exp_perr = '0;
  endtask

  // A write to a valid index replaces exactly the strobed bytes and pulses next cycle.
  task automatic model_commit(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr >> 2);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (idx < NR) begin
      model_reg[idx] = (model_reg[idx] & ~mask) | (data & mask);
      pulse_cyc[idx] = cyc_cnt + 1;
      exp_perr[idx]  = 1'b0;
    end
  endtask

  always @(negedge ACLK) begin
    cyc_cnt++;
    if (chk_en) begin
      for (int i = 0; i < NR; i++) begin
        check($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], model_reg[i]);
        check($sformatf("reg_wr_pulse[%0d]", i), 32'(reg_wr_pulse[i]), 32'(pulse_cyc[i] == cyc_cnt));
      end
      check("parity_err", 32'(parity_err), 32'(exp_perr));
    end
  end

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int bhold, input logic [1:0] exp_resp);
    int ws = (w_lead < 0) ? -w_lead : 0;
    int as_ = (w_lead > 0) ? w_lead : 0;
    bit wd = 1'b0;
    bit ad = 1'b0;
    bit w_hs;
    bit a_hs;
    int c = 0;
    logic [1:0] resp_seen;
    S_AWADDR = addr;
    S_WDATA  = data;
    S_WSTRB  = strb;
    while (!(wd && ad) && c < 20) begin
      S_WVALID  = !wd && (c >= ws);
      S_AWVALID = !ad && (c >= as_);
      w_hs = S_WVALID && S_WREADY;
      a_hs = S_AWVALID && S_AWREADY;
      step();
      wd = wd | w_hs;
      ad = ad | a_hs;
      c++;
    end
    S_WVALID  = 1'b0;
    S_AWVALID = 1'b0;
    check("wr_handshake_done", 32'({wd, ad}), 32'h3);
    check("bvalid_before_commit", 32'(S_BVALID), 32'h0);
    step();
    model_commit(addr, data, strb);
    check("bvalid_after_commit", 32'(S_BVALID), 32'h1);
    check("bresp", 32'(S_BRESP), 32'(exp_resp));
    resp_seen = S_BRESP;
    $display("write addr=0x%02h data=0x%08h strb=%b bresp=%b", addr, data, strb, S_BRESP);
    for (int h = 0; h < bhold; h++) begin
      step();
      check("bvalid_hold", 32'(S_BVALID), 32'h1);
      check("bresp_hold", 32'(S_BRESP), 32'(resp_seen));
      check("awready_hold", 32'(S_AWREADY), 32'h0);
      check("wready_hold", 32'(S_WREADY), 32'h0);
    end
    S_BREADY = 1'b1;
    step();
    S_BREADY = 1'b0;
    check("bvalid_cleared", 32'(S_BVALID), 32'h0);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int rhold);
    int idx = int'(addr >> 2);
    logic [31:0] mdl;
    logic [31:0] seen;
    mdl = 32'h0;
    if (idx < NR) mdl = model_reg[idx];
    S_ARADDR  = addr;
    S_ARVALID = 1'b1;
    check("arready_idle", 32'(S_ARREADY), 32'h1);
    step();
    S_ARVALID = 1'b0;
    if (exp_resp == ERR && idx < NR) exp_perr[idx] = 1'b1;
    check("rvalid", 32'(S_RVALID), 32'h1);
    check("rdata", S_RDATA, exp_data);
    check("rdata_model", S_RDATA, mdl);
    check("rresp", 32'(S_RRESP), 32'(exp_resp));
    seen = S_RDATA;
    $display("read  addr=0x%02h rdata=0x%08h rresp=%b", addr, S_RDATA, S_RRESP);
    for (int h = 0; h < rhold; h++) begin
      step();
      check("rvalid_hold", 32'(S_RVALID), 32'h1);
      check("rdata_hold", S_RDATA, seen);
      check("arready_hold", 32'(S_ARREADY), 32'h0);
    end
    S_RREADY = 1'b1;
    step();
    S_RREADY = 1'b0;
    check("rvalid_cleared", 32'(S_RVALID), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    ARESETN = 1'b0;
    repeat (3) step();
    ARESETN = 1'b1;
    step();
    check("rst_awready", 32'(S_AWREADY), 32'h1);
    check("rst_wready", 32'(S_WREADY), 32'h1);
    check("rst_arready", 32'(S_ARREADY), 32'h1);
    check("rst_bvalid", 32'(S_BVALID), 32'h0);
    check("rst_rvalid", 32'(S_RVALID), 32'h0);
    check("rst_bresp", 32'(S_BRESP), 32'h0);
    check("rst_rresp", 32'(S_RRESP), 32'h0);
    check("rst_rdata", S_RDATA, 32'h0);
    chk_en = 1'b1;

    // Basic writes with W together, AW first, W first, then read back.
    do_write(8'h00, 32'h1, 4'hF, 0, 0, OK);
    do_write(8'h04, 32'h2, 4'hF, -2, 0, OK);
    do_write(8'h08, 32'h3, 4'hF, 1, 0, OK);
    do_write(8'h0C, 32'h4, 4'hF, 0, 0, OK);
    do_read(8'h00, 32'h1, OK, 0);
    do_read(8'h04, 32'h2, OK, 0);
    do_read(8'h08, 32'h3, OK, 0);
    do_read(8'h0C, 32'h4, OK, 0);

    // W three cycles ahead of AW, low half-word strobes.
    do_write(8'h04, 32'hDEADBEEF, 4'b0011, 3, 0, OK);
    check("reg1_merge_literal", reg_q[63:32], 32'h0000BEEF);
    do_read(8'h04, 32'h0000BEEF, OK, 0);

    // Decode errors on first out-of-range and topmost index; low address bits ignored.
    do_write(8'h10, 32'hFFFFFFFF, 4'hF, 0, 0, ERR);
    do_read(8'h10, 32'h0, ERR, 0);
    do_read(8'hFC, 32'h0, ERR, 0);
    do_write(8'h0C, 32'h12345678, 4'b0000, 0, 0, OK);
    do_read(8'h0E, 32'h4, OK, 0);

    // Backpressure on B and R for ten cycles.
    do_write(8'h08, 32'hCAFE0002, 4'hF, 0, 10, OK);
    do_read(8'h08, 32'hCAFE0002, OK, 10);

    // Read and write of the same register resolving on the same edge.
    do_write(8'h08, 32'h5, 4'hF, 0, 0, OK);
    S_AWADDR = 8'h08; S_AWVALID = 1'b1;
    S_WDATA = 32'h6; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    step();
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    S_ARADDR = 8'h08; S_ARVALID = 1'b1;
    check("same_edge_arready", 32'(S_ARREADY), 32'h1);
    step();
    S_ARVALID = 1'b0;
    model_commit(8'h08, 32'h6, 4'hF);
    check("same_edge_bvalid", 32'(S_BVALID), 32'h1);
    check("same_edge_rvalid", 32'(S_RVALID), 32'h1);
    check("same_edge_rdata_old", S_RDATA, 32'h5);
    $display("read  addr=0x08 rdata=0x%08h rresp=%b (same edge as write)", S_RDATA, S_RRESP);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    step();
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    do_read(8'h08, 32'h6, OK, 0);

    // Reset with only W buffered: the stale W must not pair with a later AW.
    do_write(8'h0C, 32'h77, 4'hF, 0, 0, OK);
    S_WDATA = 32'h99; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    check("pre_reset_wready", 32'(S_WREADY), 32'h1);
    step();
    S_WVALID = 1'b0;
    #2;
    ARESETN = 1'b0;
    model_clear();
    #1;
    check("async_reset_reg3", reg_q[127:96], 32'h0);
    check("async_reset_bvalid", 32'(S_BVALID), 32'h0);
    step();
    ARESETN = 1'b1;
    S_AWADDR = 8'h0C; S_AWVALID = 1'b1;
    check("post_reset_awready", 32'(S_AWREADY), 32'h1);
    step();
    S_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("no_commit_stale_w", 32'(S_BVALID), 32'h0);
      step();
    end
    S_WDATA = 32'hAB; S_WVALID = 1'b1;
    check("post_reset_wready", 32'(S_WREADY), 32'h1);
    step();
    S_WVALID = 1'b0;
    check("post_reset_bvalid_early", 32'(S_BVALID), 32'h0);
    step();
    model_commit(8'h0C, 32'hAB, 4'hF);
    check("post_reset_bvalid", 32'(S_BVALID), 32'h1);
    $display("write addr=0x0c data=0x000000ab strb=1111 bresp=%b (after reset)", S_BRESP);
    S_BREADY = 1'b1;
    step();
    S_BREADY = 1'b0;
    do_read(8'h0C, 32'hAB, OK, 0);

`ifdef AXIL_REG_BANK_PARITY_EN
    do_write(8'h00, 32'hA5, 4'hF, 0, 0, OK);
    force u_dut.g_reg[0].data_q = 32'hA4;
    model_reg[0] = 32'hA4;
    step();
    release u_dut.g_reg[0].data_q;
    do_read(8'h00, 32'hA4, ERR, 0);
    check("parity_err0_set", 32'(parity_err[0]), 32'h1);
    do_write(8'h00, 32'h1, 4'hF, 0, 0, OK);
    check("parity_err0_clear", 32'(parity_err[0]), 32'h0);
    do_read(8'h00, 32'h1, OK, 0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
